// File: rtl/ov5640_init_sequencer.sv
// ov5640_init_sequencer: walks the OV5640 register table and issues one IIC write per entry
// Ports: i_clk/i_rstn clock and async active-low reset; i_start (re)start pulse;
//   o_rom_addr/i_rom_data table read with 1-cycle latency; o_iic_req/o_iic_addr/o_iic_data
//   write request to the IIC master, answered by i_iic_done/i_iic_err;
//   o_busy/o_done/o_error sequence status
module ov5640_init_sequencer #(
  parameter int CLOCK_FREQ_MHZ   = 65,
  parameter int TABLE_LEN        = 252,
  parameter int POWERUP_DELAY_MS = 20,
  parameter int MAX_RETRY        = 3,
  parameter int AUTO_START       = 1
) (
  input  logic        i_clk,
  input  logic        i_rstn,
  input  logic        i_start,
  output logic [7:0]  o_rom_addr,
  input  logic [23:0] i_rom_data,
  output logic        o_iic_req,
  output logic [15:0] o_iic_addr,
  output logic [7:0]  o_iic_data,
  input  logic        i_iic_done,
  input  logic        i_iic_err,
  output logic        o_busy,
  output logic        o_done,
  output logic        o_error
);
  localparam int TICKS = CLOCK_FREQ_MHZ * 1000;
  localparam int PW = $clog2(TICKS);
  localparam int MW = POWERUP_DELAY_MS > 255 ? $clog2(POWERUP_DELAY_MS + 1) : 8;
  localparam int RW = MAX_RETRY > 0 ? $clog2(MAX_RETRY + 1) : 1;
  localparam logic [PW-1:0] PRE_LAST = PW'(TICKS - 1);
  // Timed waits start part-way into their first ms so the fixed fetch/latch/issue
  // pipeline around them is absorbed and requests land on the ms boundary.
  localparam logic [PW-1:0] PWR_SKEW = PW'(4);
  localparam logic [PW-1:0] DLY_SKEW = PW'(1);
  localparam logic [PW-1:0] BCK_SKEW = PW'(2);
  typedef enum logic [3:0] {
    IDLE, PWR_WAIT, FETCH, LATCH, ISSUE, WAIT_DONE, DELAY, BACKOFF, DONE, ERROR
  } state_t;
  state_t state_q, state_d, adv_state;
  logic [7:0] idx_q, idx_d, adv_idx;
  logic [RW-1:0] retry_q, retry_d;
  logic [PW-1:0] pre_q, pre_d;
  logic [MW-1:0] ms_q, ms_d, tgt_q, tgt_d;
  logic [15:0] addr_q, addr_d;
  logic [7:0] data_q, data_d;
  logic req_q, req_d, tick, expired, last, busy;
  assign busy = !(state_q inside {IDLE, DONE, ERROR});
  always_comb begin
    state_d = state_q;
    idx_d = idx_q;
    retry_d = retry_q;
    tgt_d = tgt_q;
    addr_d = addr_q;
    data_d = data_q;
    req_d = req_q;
    tick = pre_q == PRE_LAST;
    pre_d = tick ? '0 : pre_q + PW'(1);
    ms_d = tick ? ms_q + MW'(1) : ms_q;
    expired = tick && ms_q == tgt_q - MW'(1);
    last = idx_q == 8'(TABLE_LEN - 1);
    adv_state = last ? DONE : FETCH;
    adv_idx = last ? idx_q : idx_q + 8'd1;
    if ((state_q == IDLE && AUTO_START != 0) || (i_start && !busy)) begin
      state_d = POWERUP_DELAY_MS == 0 ? FETCH : PWR_WAIT;
      idx_d = '0;
      retry_d = '0;
      tgt_d = MW'(POWERUP_DELAY_MS);
      pre_d = PWR_SKEW;
      ms_d = '0;
    end else begin
      case (state_q)
        PWR_WAIT: state_d = expired ? FETCH : PWR_WAIT;
        FETCH: state_d = LATCH;
        LATCH: begin
          if (i_rom_data[23:8] == 16'hFFFF) begin
            state_d = i_rom_data[7:0] == 8'd0 ? adv_state : DELAY;
            idx_d = i_rom_data[7:0] == 8'd0 ? adv_idx : idx_q;
            tgt_d = MW'(i_rom_data[7:0]);
            pre_d = DLY_SKEW;
            ms_d = '0;
          end else begin
            addr_d = i_rom_data[23:8];
            data_d = i_rom_data[7:0];
            state_d = ISSUE;
          end
        end
        ISSUE: begin
          req_d = 1'b1;
          state_d = WAIT_DONE;
        end
        WAIT_DONE: begin
          if (i_iic_done) begin
            req_d = 1'b0;
            if (!i_iic_err) begin
              retry_d = '0;
              state_d = adv_state;
              idx_d = adv_idx;
            end else if (retry_q < RW'(MAX_RETRY)) begin
              retry_d = retry_q + RW'(1);
              state_d = BACKOFF;
              tgt_d = MW'(1);
              pre_d = BCK_SKEW;
              ms_d = '0;
            end else begin
              state_d = ERROR;
            end
          end
        end
        DELAY: begin
          state_d = expired ? adv_state : DELAY;
          idx_d = expired ? adv_idx : idx_q;
        end
        BACKOFF: state_d = expired ? ISSUE : BACKOFF;
        default: ;
      endcase
    end
  end
  always_ff @(posedge i_clk or negedge i_rstn) begin
    if (!i_rstn) begin
      state_q <= IDLE;
      idx_q <= '0;
      retry_q <= '0;
      pre_q <= '0;
      ms_q <= '0;
      tgt_q <= '0;
      addr_q <= '0;
      data_q <= '0;
      req_q <= 1'b0;
    end else begin
      state_q <= state_d;
      idx_q <= idx_d;
      retry_q <= retry_d;
      pre_q <= pre_d;
      ms_q <= ms_d;
      tgt_q <= tgt_d;
      addr_q <= addr_d;
      data_q <= data_d;
      req_q <= req_d;
    end
  end
  assign o_rom_addr = idx_q;
  assign o_iic_req = req_q;
  assign o_iic_addr = addr_q;
  assign o_iic_data = data_q;
  assign o_busy = busy;
  assign o_done = state_q == DONE;
  assign o_error = state_q == ERROR;
endmodule

// File: tb/tb_ov5640_init_sequencer.sv
// tb_ov5640_init_sequencer: directed bench for the init sequencer (auto-start and manual-start instances)
module tb_ov5640_init_sequencer;
  logic clk = 1'b0;
  logic rstn = 1'b0;
  logic start [2];
  logic done [2];
  logic err [2];
  logic req [2];
  logic busy [2];
  logic dn [2];
  logic er [2];
  logic [7:0] ra [2];
  logic [23:0] rd [2];
  logic [15:0] ia [2];
  logic [7:0] id [2];
  logic [23:0] rom [4];
  int cyc = 0;
  int n_chk = 0;
  int n_fail = 0;
  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;
  always @(posedge clk) begin
    rd[0] <= rom[ra[0][1:0]];
    rd[1] <= rom[ra[1][1:0]];
  end
  ov5640_init_sequencer #(.CLOCK_FREQ_MHZ(1), .TABLE_LEN(3), .POWERUP_DELAY_MS(2),
    .MAX_RETRY(3), .AUTO_START(1)) u0 (
    .i_clk(clk), .i_rstn(rstn), .i_start(start[0]), .o_rom_addr(ra[0]), .i_rom_data(rd[0]),
    .o_iic_req(req[0]), .o_iic_addr(ia[0]), .o_iic_data(id[0]), .i_iic_done(done[0]),
    .i_iic_err(err[0]), .o_busy(busy[0]), .o_done(dn[0]), .o_error(er[0]));
  ov5640_init_sequencer #(.CLOCK_FREQ_MHZ(1), .TABLE_LEN(3), .POWERUP_DELAY_MS(2),
    .MAX_RETRY(3), .AUTO_START(0)) u1 (
    .i_clk(clk), .i_rstn(rstn), .i_start(start[1]), .o_rom_addr(ra[1]), .i_rom_data(rd[1]),
    .o_iic_req(req[1]), .o_iic_addr(ia[1]), .o_iic_data(id[1]), .i_iic_done(done[1]),
    .i_iic_err(err[1]), .o_busy(busy[1]), .o_done(dn[1]), .o_error(er[1]));
  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_chk++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: got %0h want %0h", tag, obs, exp);
    end
  endtask
  task automatic chk_rng(input string tag, input int v, input int lo, input int hi);
    n_chk++;
    assert (v >= lo && v <= hi) else begin
      n_fail++;
      $error("FAIL %s: got %0d want %0d..%0d", tag, v, lo, hi);
    end
  endtask
  task automatic tick(input int k);
    repeat (k) @(negedge clk);
  endtask
  task automatic wait_req(input int u, output int t);
    int i = 0;
    while (!req[u] && i < 20000) begin
      @(negedge clk);
      i++;
    end
    t = cyc;
    chk("req_seen", 32'(req[u]), 1);
  endtask
  task automatic iic(input int u, input logic e, output int t);
    tick(10);
    done[u] = 1'b1;
    err[u] = e;
    t = cyc;
    tick(1);
    done[u] = 1'b0;
    err[u] = 1'b0;
  endtask
  task automatic pulse_start(input int u, output int t);
    start[u] = 1'b1;
    t = cyc;
    tick(1);
    start[u] = 1'b0;
  endtask
  task automatic no_req(input int u, input int k);
    int hit = 0;
    repeat (k) begin
      @(negedge clk);
      if (req[u]) hit++;
    end
    chk("no_req", hit, 0);
  endtask
  task automatic write(input int u, input logic [15:0] a, input logic [7:0] d, input logic e,
                       output int tr, output int td);
    wait_req(u, tr);
    chk("iic_addr", 32'(ia[u]), 32'(a));
    chk("iic_data", 32'(id[u]), 32'(d));
    iic(u, e, td);
  endtask
  initial begin
    int t0, tr, td, tn;
    for (int i = 0; i < 2; i++) begin
      start[i] = 1'b0;
      done[i] = 1'b0;
      err[i] = 1'b0;
    end
    rom[0] = 24'h300882;
    rom[1] = 24'h310303;
    rom[2] = 24'h3017FF;
    rom[3] = 24'h000000;
    tick(3);
    chk("rst_req", 32'(req[0]), 0);
    chk("rst_rom_addr", 32'(ra[0]), 0);
    chk("rst_iic_addr", 32'(ia[0]), 0);
    chk("rst_iic_data", 32'(id[0]), 0);
    chk("rst_busy", 32'(busy[0]), 0);
    chk("rst_done", 32'(dn[0]), 0);
    chk("rst_error", 32'(er[0]), 0);
    rstn = 1'b1;
    t0 = cyc;
    tick(1);
    chk("pwr_busy", 32'(busy[0]), 1);
    write(0, 16'h3008, 8'h82, 1'b0, tr, td);
    chk_rng("pwr_delay", tr - t0, 1999, 2001);
    write(0, 16'h3103, 8'h03, 1'b0, tr, tn);
    chk("gap_w2", tr - td, 4);
    write(0, 16'h3017, 8'hFF, 1'b0, tr, td);
    tick(1);
    chk("done_set", 32'(dn[0]), 1);
    chk("done_busy", 32'(busy[0]), 0);
    no_req(0, 50);
    rom[1] = 24'hFFFF05;
    rom[2] = 24'h310303;
    pulse_start(0, t0);
    chk("restart_done_clr", 32'(dn[0]), 0);
    write(0, 16'h3008, 8'h82, 1'b0, tr, td);
    write(0, 16'h3103, 8'h03, 1'b0, tr, tn);
    chk_rng("delay_gap", tr - td, 5003, 5005);
    tick(1);
    chk("delay_done", 32'(dn[0]), 1);
    no_req(0, 50);
    rom[1] = 24'h310303;
    rom[2] = 24'h3017FF;
    pulse_start(0, t0);
    write(0, 16'h3008, 8'h82, 1'b0, tr, td);
    write(0, 16'h3103, 8'h03, 1'b1, tr, td);
    write(0, 16'h3103, 8'h03, 1'b1, tr, tn);
    chk("retry1_gap", tr - td, 1000);
    write(0, 16'h3103, 8'h03, 1'b0, tr, td);
    chk("retry2_gap", tr - tn, 1000);
    write(0, 16'h3017, 8'hFF, 1'b0, tr, td);
    tick(1);
    chk("retry_done", 32'(dn[0]), 1);
    chk("retry_no_error", 32'(er[0]), 0);
    pulse_start(0, t0);
    write(0, 16'h3008, 8'h82, 1'b0, tr, td);
    for (int i = 0; i < 4; i++) write(0, 16'h3103, 8'h03, 1'b1, tr, td);
    tick(1);
    chk("nack_error", 32'(er[0]), 1);
    chk("nack_busy", 32'(busy[0]), 0);
    chk("nack_rom_addr", 32'(ra[0]), 1);
    no_req(0, 1500);
    pulse_start(0, t0);
    chk("err_clr", 32'(er[0]), 0);
    chk("err_restart_busy", 32'(busy[0]), 1);
    chk("err_restart_idx", 32'(ra[0]), 0);
    wait_req(0, tr);
    chk("err_restart_addr", 32'(ia[0]), 32'h3008);
    tick(3);
    rstn = 1'b0;
    #1;
    chk("arst_req", 32'(req[0]), 0);
    chk("arst_iic_addr", 32'(ia[0]), 0);
    chk("arst_busy", 32'(busy[0]), 0);
    chk("arst_rom_addr", 32'(ra[0]), 0);
    tick(2);
    rstn = 1'b1;
    t0 = cyc;
    write(0, 16'h3008, 8'h82, 1'b0, tr, td);
    chk_rng("arst_pwr_delay", tr - t0, 1999, 2001);
    no_req(1, 10000);
    chk("manual_idle", 32'(busy[1]), 0);
    pulse_start(1, t0);
    chk("manual_busy", 32'(busy[1]), 1);
    write(1, 16'h3008, 8'h82, 1'b0, tr, td);
    chk_rng("manual_pwr_delay", tr - t0, 1999, 2001);
    wait_req(1, tr);
    chk("manual_w2_addr", 32'(ia[1]), 32'h3103);
    tick(10);
    done[1] = 1'b1;
    start[1] = 1'b1;
    td = cyc;
    tick(1);
    done[1] = 1'b0;
    start[1] = 1'b0;
    write(1, 16'h3017, 8'hFF, 1'b0, tr, tn);
    chk("busy_start_ignored_gap", tr - td, 4);
    tick(1);
    chk("manual_done", 32'(dn[1]), 1);
    chk("manual_done_busy", 32'(busy[1]), 0);
    $display("%0d/%0d checks passed", n_chk - n_fail, n_chk);
    $finish;
  end
endmodule

// File: doc/ov5640_init_sequencer.md
# ov5640_init_sequencer

Walks a register-initialisation table and issues one IIC register write per entry to the IIC master, which performs the bus transfer. Supports power-up delay, in-table delay entries, bounded retry on NACK, and done/error status. Sits between the table ROM and the IIC master on the pixel-clock domain. Its status gates the camera datapath start.

## Interface
- CLOCK_FREQ_MHZ, 65, i_clk frequency; one ms tick = CLOCK_FREQ_MHZ*1000 cycles
- TABLE_LEN, 252, number of table entries (1..256)
- POWERUP_DELAY_MS, 20, wait before first entry
- MAX_RETRY, 3, extra attempts per entry after NACK
- AUTO_START, 1, 1 = start sequence after reset release

- i_clk  in  1  clock; all logic rising-edge
- i_rstn  in  1  reset, asynchronous, active-low
- i_start  in  1  pulse; starts or restarts the sequence when not busy
- o_rom_addr  out  8  table index
- i_rom_data  in  24  {reg_addr[23:8], reg_data[7:0]}; valid 1 cycle after o_rom_addr
- o_iic_req  out  1  write request, level
- o_iic_addr  out  16  register address, stable while o_iic_req
- o_iic_data  out  8  register data, stable while o_iic_req
- i_iic_done  in  1  1-cycle pulse, transaction finished
- i_iic_err  in  1  NACK flag, sampled only with i_iic_done
- o_busy  out  1  sequence in progress
- o_done  out  1  table completed, held until next start
- o_error  out  1  retries exhausted, held until next start

## Operation
- States: IDLE, PWR_WAIT, FETCH, LATCH, ISSUE, WAIT_DONE, DELAY, BACKOFF, DONE, ERROR.
- IDLE: after reset, goes to PWR_WAIT if AUTO_START=1; otherwise waits for i_start.
- i_start in IDLE, DONE or ERROR: clear o_done, o_error, index and retry count; go to PWR_WAIT. Ignored while o_busy.
- PWR_WAIT: count POWERUP_DELAY_MS ms ticks, then FETCH. POWERUP_DELAY_MS=0 goes to FETCH directly.
- FETCH: drive o_rom_addr = index, then LATCH.
- LATCH: capture i_rom_data.
  - If reg_addr = 16'hFFFF, the entry is a delay: go to DELAY for reg_data ms (0 = no wait).
  - Otherwise load o_iic_addr/o_iic_data and go to ISSUE.
- ISSUE: assert o_iic_req, then WAIT_DONE. Hold o_iic_req until the cycle of i_iic_done; deassert on the next edge.
- WAIT_DONE with i_iic_done:
  - i_iic_err=0: clear retry count, index+1.
  - i_iic_err=1 and retry count < MAX_RETRY: retry count+1, go to BACKOFF (1 ms), then ISSUE with the same addr/data.
  - i_iic_err=1 and retries exhausted: go to ERROR.
- Index advance: if index+1 = TABLE_LEN, go to DONE; otherwise FETCH.
- DONE: o_done=1. ERROR: o_error=1, o_rom_addr holds the failing index.
- o_busy=1 in every state except IDLE, DONE and ERROR.
- Counter widths:
  - ms prescaler: ceil(log2(CLOCK_FREQ_MHZ*1000)) bits.
  - ms counter: 8 bits, or more if POWERUP_DELAY_MS > 255.
  - Retry counter: ceil(log2(MAX_RETRY+1)) bits. No wrap is possible.

## Timing
- Reset values: o_rom_addr=0, o_iic_req=0, o_iic_addr=0, o_iic_data=0, o_busy=0, o_done=0, o_error=0; state IDLE.
- Async reset mid-transfer forces o_iic_req=0 immediately. Terminating the IIC master is its own concern.
- Per-entry overhead: FETCH→LATCH→ISSUE = 3 cycles to o_iic_req rise. After i_iic_done, the next o_iic_req rises 4 cycles later (WAIT_DONE→FETCH→LATCH→ISSUE).
- Delay of N ms = exactly N*CLOCK_FREQ_MHZ*1000 cycles ±1, measured from LATCH exit to FETCH entry.
- i_iic_done outside WAIT_DONE is ignored. i_iic_done and i_start in the same cycle: i_start is ignored because o_busy=1.

## Test plan
- CLOCK_FREQ_MHZ=1, POWERUP_DELAY_MS=2, TABLE_LEN=3, table {3008/82, 3103/03, 3017/FF}; IIC model answers done 10 cycles after req.
  - Required: first o_iic_req 2000±1 cycles after reset release.
  - Required: exactly 3 writes, with addr/data matching the table in order.
  - Required: o_done=1 and o_busy=0 after the third done.
- Delay entry {FFFF/05} between two writes -> gap between the write-1 done and the write-2 req is 5000±1 + 4 cycles; no req for the delay entry.
- NACK on entry 1 twice, then ACK, with MAX_RETRY=3 -> 3 reqs with identical addr/data, each retry 1000 cycles after the NACK, then the sequence proceeds; o_error=0.
- NACK always, MAX_RETRY=3 -> 4 attempts, then o_error=1, o_busy=0, o_rom_addr=failing index. i_start then restarts from index 0 and clears o_error.
- Assert i_rstn=0 while o_iic_req=1 -> o_iic_req=0 within the same cycle and all outputs at reset values. After release with AUTO_START=1, the sequence restarts at index 0.
- AUTO_START=0 -> no req for 10000 cycles; i_start pulse -> sequence runs. Second i_start while busy -> no effect on index.
